bcd_timer_counter: RTL and testbench

//  Parametrised multi-digit BCD up/down timer; successor to the fixed MM:SS stopwatch counter.

---
 rtl/bcd_timer_counter_pkg.sv | 13 +
 rtl/bcd_digit_cell.sv | 31 +++
 rtl/bcd_timer_counter.sv | 119 +++++++++++
 tb/tb_bcd_timer_counter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_counter_pkg.sv
// Shared definitions for the BCD timer counter: step modes and digit width.
package bcd_timer_counter_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit with a programmable modulus: increments or decrements and
// reports when it wraps so the next digit can ripple in the same cycle.
module bcd_digit_cell
  import bcd_timer_counter_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_value,
  input  logic [DIGIT_W-1:0] i_modulus,
  input  logic               i_inc,
  input  logic               i_dec,
  output logic [DIGIT_W-1:0] o_next,
  output logic               o_carry,
  output logic               o_borrow
);

  logic [DIGIT_W-1:0] w_top;

  assign w_top    = i_modulus - DIGIT_W'(1);
  assign o_carry  = i_inc && (i_value == w_top);
  assign o_borrow = i_dec && (i_value == '0);

  always_comb begin
    // NOTE: o_next is given a value on every path so no latch is inferred.
    o_next = i_value;
    if (i_inc) begin
      o_next = o_carry ? '0 : i_value + DIGIT_W'(1);
    end else if (i_dec) begin
      o_next = o_borrow ? w_top : i_value - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_timer_counter.sv
// Multi-digit BCD up/down timer with per-digit modulus, wrap or saturate at
// the limits, rollover/borrow pulses and a sticky down-count expiry alarm.
module bcd_timer_counter
  import bcd_timer_counter_pkg::*;
#(
  parameter int                           NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0]      DIGIT_MOD  = {4'd10, 4'd6, 4'd10, 4'd10},
  parameter bit                           WRAP_EN    = 1'b1
) (
  input  logic                    clk_1Hz,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [1:0]              mode,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    carry,
  output logic                    borrow,
  output logic                    at_zero,
  output logic                    alarm
);

  localparam int W = DIGIT_W * NUM_DIGITS;

  mode_e           w_mode;
  logic [NUM_DIGITS:0] w_inc;
  logic [NUM_DIGITS:0] w_dec;
  logic [W-1:0]    w_step;
  logic [W-1:0]    w_clamped;
  logic [W-1:0]    w_next;
  logic            w_carry_next;
  logic            w_borrow_next;
  logic            w_alarm_next;

  logic [W-1:0]    r_digits;
  logic            r_carry;
  logic            r_borrow;
  logic            r_at_zero;
  logic            r_alarm;

  assign w_mode   = mode_e'(mode);
  assign w_inc[0] = (w_mode == MODE_UP);
  assign w_dec[0] = (w_mode == MODE_DOWN);

  // Carry/borrow out of the top digit means the whole count sat at its limit.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [DIGIT_W-1:0] w_ld;
    logic [DIGIT_W-1:0] w_top;

    assign w_ld  = load_val[g*DIGIT_W +: DIGIT_W];
    assign w_top = DIGIT_MOD[g*DIGIT_W +: DIGIT_W] - DIGIT_W'(1);
    assign w_clamped[g*DIGIT_W +: DIGIT_W] = (w_ld > w_top) ? w_top : w_ld;

    bcd_digit_cell u_cell (
      .i_value   (r_digits[g*DIGIT_W +: DIGIT_W]),
      .i_modulus (DIGIT_MOD[g*DIGIT_W +: DIGIT_W]),
      .i_inc     (w_inc[g]),
      .i_dec     (w_dec[g]),
      .o_next    (w_step[g*DIGIT_W +: DIGIT_W]),
      .o_carry   (w_inc[g+1]),
      .o_borrow  (w_dec[g+1])
    );
  end

  always_comb begin
    w_next        = r_digits;
    w_carry_next  = 1'b0;
    w_borrow_next = 1'b0;
    w_alarm_next  = r_alarm;
    unique case (w_mode)
      MODE_HOLD: ;
      MODE_UP: begin
        if (!w_inc[NUM_DIGITS] || WRAP_EN) w_next = w_step;
        w_carry_next = w_inc[NUM_DIGITS] && WRAP_EN;
      end
      MODE_DOWN: begin
        if (!w_dec[NUM_DIGITS] || WRAP_EN) w_next = w_step;
        w_borrow_next = w_dec[NUM_DIGITS] && WRAP_EN;
        // Expiry: either this step lands on zero or it tried to go below zero.
        if (w_dec[NUM_DIGITS] || (w_step == '0)) w_alarm_next = 1'b1;
      end
      MODE_LOAD: begin
        w_next       = w_clamped;
        w_alarm_next = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      r_digits  <= '0;
      r_carry   <= 1'b0;
      r_borrow  <= 1'b0;
      r_at_zero <= 1'b1;
      r_alarm   <= 1'b0;
    end else if (clear) begin
      r_digits  <= '0;
      r_carry   <= 1'b0;
      r_borrow  <= 1'b0;
      r_at_zero <= 1'b1;
      r_alarm   <= 1'b0;
    end else begin
      r_digits  <= w_next;
      r_carry   <= w_carry_next;
      r_borrow  <= w_borrow_next;
      r_at_zero <= (w_next == '0);
      r_alarm   <= w_alarm_next;
    end
  end

  assign digits  = r_digits;
  assign carry   = r_carry;
  assign borrow  = r_borrow;
  assign at_zero = r_at_zero;
  assign alarm   = r_alarm;

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Random and directed checks of three counter variants (wrap, saturate, HH:MM:SS)
// against a mixed-radix integer model of the count.
module tb_bcd_timer_counter;
  import bcd_timer_counter_pkg::*;

  localparam logic [15:0] MOD4 = {4'd10, 4'd6, 4'd10, 4'd10};
  localparam logic [23:0] MOD6 = 24'h3A6A6A;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [1:0]  mode;
  logic [23:0] ld;

  logic [15:0] dig_w, dig_s;
  logic [23:0] dig_h;
  logic        cy_w, cy_s, cy_h, bw_w, bw_s, bw_h;
  logic        az_w, az_s, az_h, al_w, al_s, al_h;

  always #5 clk = ~clk;

  bcd_timer_counter #(.NUM_DIGITS(4), .DIGIT_MOD(MOD4), .WRAP_EN(1'b1)) u_dut_wrap (
    .clk_1Hz(clk), .reset(reset), .clear(clear), .mode(mode), .load_val(ld[15:0]),
    .digits(dig_w), .carry(cy_w), .borrow(bw_w), .at_zero(az_w), .alarm(al_w));

  bcd_timer_counter #(.NUM_DIGITS(4), .DIGIT_MOD(MOD4), .WRAP_EN(1'b0)) u_dut_sat (
    .clk_1Hz(clk), .reset(reset), .clear(clear), .mode(mode), .load_val(ld[15:0]),
    .digits(dig_s), .carry(cy_s), .borrow(bw_s), .at_zero(az_s), .alarm(al_s));

  bcd_timer_counter #(.NUM_DIGITS(6), .DIGIT_MOD(MOD6), .WRAP_EN(1'b1)) u_dut_hms (
    .clk_1Hz(clk), .reset(reset), .clear(clear), .mode(mode), .load_val(ld),
    .digits(dig_h), .carry(cy_h), .borrow(bw_h), .at_zero(az_h), .alarm(al_h));

  int          nd[3]   = '{4, 4, 6};
  logic [23:0] mods[3] = '{{8'h00, MOD4}, {8'h00, MOD4}, MOD6};
  bit          wrap[3] = '{1'b1, 1'b0, 1'b1};

  int m_val[3];
  bit m_carry[3], m_borrow[3], m_alarm[3];

  int n_vec = 0;
  int n_err = 0;

  function automatic int modulus(int k, int i);
    logic [23:0] m;
    m = mods[k];
    return int'(m[4*i +: 4]);
  endfunction

  function automatic int max_int(int k);
    int p = 1;
    for (int i = 0; i < nd[k]; i++) p *= modulus(k, i);
    return p - 1;
  endfunction

  // Clamped packed BCD -> integer count in the variant's mixed radix.
  function automatic int to_int(int k, logic [23:0] b);
    int v = 0;
    int w = 1;
    for (int i = 0; i < nd[k]; i++) begin
      int d;
      d = int'(b[4*i +: 4]);
      if (d > modulus(k, i) - 1) d = modulus(k, i) - 1;
      v += d * w;
      w *= modulus(k, i);
    end
    return v;
  endfunction

  function automatic logic [23:0] to_bcd(int k, int v);
    logic [23:0] r = '0;
    int x = v;
    for (int i = 0; i < nd[k]; i++) begin
      r[4*i +: 4] = 4'(x % modulus(k, i));
      x = x / modulus(k, i);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_val[k] = 0; m_carry[k] = 0; m_borrow[k] = 0; m_alarm[k] = 0;
    end
  endtask

  task automatic model_step(int k, logic [1:0] md, logic clr, logic [23:0] l);
    m_carry[k]  = 0;
    m_borrow[k] = 0;
    if (clr) begin
      m_val[k] = 0; m_alarm[k] = 0;
    end else begin
      case (md)
        2'd1: begin
          if (m_val[k] == max_int(k)) begin
            if (wrap[k]) begin m_val[k] = 0; m_carry[k] = 1; end
          end else m_val[k] = m_val[k] + 1;
        end
        2'd2: begin
          if (m_val[k] == 0) begin
            m_alarm[k] = 1;
            if (wrap[k]) begin m_val[k] = max_int(k); m_borrow[k] = 1; end
          end else begin
            m_val[k] = m_val[k] - 1;
            if (m_val[k] == 0) m_alarm[k] = 1;
          end
        end
        2'd3: begin
          m_val[k] = to_int(k, l); m_alarm[k] = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all(string tag);
    logic [23:0] d;
    logic cy, bw, az, al;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin d = {8'h00, dig_w}; cy = cy_w; bw = bw_w; az = az_w; al = al_w; end
        1:       begin d = {8'h00, dig_s}; cy = cy_s; bw = bw_s; az = az_s; al = al_s; end
        default: begin d = dig_h;          cy = cy_h; bw = bw_h; az = az_h; al = al_h; end
      endcase
      check($sformatf("%s/d%0d.digits", tag, k), 32'(d), 32'(to_bcd(k, m_val[k])));
      check($sformatf("%s/d%0d.carry", tag, k), 32'(cy), 32'(m_carry[k]));
      check($sformatf("%s/d%0d.borrow", tag, k), 32'(bw), 32'(m_borrow[k]));
      check($sformatf("%s/d%0d.at_zero", tag, k), 32'(az), 32'(m_val[k] == 0));
      check($sformatf("%s/d%0d.alarm", tag, k), 32'(al), 32'(m_alarm[k]));
    end
  endtask

  // Called at a falling edge: drive, take one rising edge, compare at the next falling edge.
  task automatic apply(logic [1:0] md, logic clr, logic [23:0] l, string tag);
    mode = md; clear = clr; ld = l;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, md, clr, l);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [23:0] mx4;
    logic [23:0] mx6;
    reset = 1'b1; clear = 1'b0; mode = 2'd0; ld = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    for (int i = 0; i < 600; i++) apply(2'd1, 1'b0, '0, "up600");

    mx4 = to_bcd(0, max_int(0));
    apply(2'd3, 1'b0, {8'h23, mx4[15:0]}, "load_max");
    apply(2'd1, 1'b0, '0, "up_wrap");
    apply(2'd0, 1'b0, '0, "hold_after_wrap");

    apply(2'd3, 1'b0, 24'h000002, "load_2");
    for (int i = 0; i < 3; i++) apply(2'd2, 1'b0, '0, "down_to_zero");
    apply(2'd0, 1'b0, '0, "hold_after_borrow");

    apply(2'd3, 1'b0, 24'hFFFFFF, "load_clamp");
    apply(2'd1, 1'b1, '0, "clear_with_up");

    apply(2'd3, 1'b0, 24'h235959, "load_hms");
    apply(2'd1, 1'b0, '0, "up_hms");
    mx6 = to_bcd(2, max_int(2));
    apply(2'd3, 1'b0, mx6, "load_max6");
    apply(2'd1, 1'b0, '0, "up_wrap6");

    for (int i = 0; i < 3; i++) apply(2'd1, 1'b0, '0, "pre_async");
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("async_reset");
    @(negedge clk);
    check_all("reset_held");
    reset = 1'b0;
    apply(2'd3, 1'b0, 24'h123456, "load_post_reset");
    for (int i = 0; i < 5; i++) apply(2'd0, 1'b0, '0, "hold5");

    for (int i = 0; i < 2000; i++) begin
      int r;
      logic [1:0] md;
      r  = int'($urandom_range(0, 99));
      md = (r < 10) ? 2'd0 : (r < 50) ? 2'd1 : (r < 90) ? 2'd2 : 2'd3;
      apply(md, ($urandom_range(0, 49) == 0), 24'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
